// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3-Lite encodings, master FSM states and byte-lane helpers
// used by the UART-side AHB master.
package peripheral_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    // Data access, privileged, non-bufferable, non-cacheable
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } ahb_state_e;

    // Replicate right-justified data across every lane; the caller truncates
    // the 64-bit result to its bus width.
    function automatic logic [63:0] lane_replicate(input logic [63:0] d,
                                                   input logic [2:0]  size);
        logic [63:0] r;
        case (size)
            HSIZE_BYTE:  r = {8{d[7:0]}};
            HSIZE_HWORD: r = {4{d[15:0]}};
            HSIZE_WORD:  r = {2{d[31:0]}};
            default:     r = d;
        endcase
        return r;
    endfunction

    // Move the addressed lane down to bit 0 and zero everything above it.
    function automatic logic [63:0] lane_extract(input logic [63:0] d,
                                                 input logic [2:0]  addr_lo,
                                                 input logic [2:0]  size,
                                                 input int          dw);
        logic [2:0]  off;
        logic [63:0] s;
        off = addr_lo & 3'((dw / 8) - 1);
        s   = d >> {off, 3'b000};
        case (size)
            HSIZE_BYTE:  s = {56'd0, s[7:0]};
            HSIZE_HWORD: s = {48'd0, s[15:0]};
            HSIZE_WORD:  s = {32'd0, s[31:0]};
            default:     s = s;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/peripheral_uart_ahb3_master.sv
// Single-outstanding AHB3-Lite master: one valid/ready command becomes one
// AHB single transfer toward the UART bridge, with one response returned.
module peripheral_uart_ahb3_master
    import peripheral_ahb3_pkg::*;
#(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [HADDR_SIZE-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [HDATA_SIZE-1:0] cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [HDATA_SIZE-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic                  HSEL,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam int LANE_W = $clog2(HDATA_SIZE / 8);

    ahb_state_e state_q, state_d;

    logic [HADDR_SIZE-1:0] addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic [HDATA_SIZE-1:0] wdata_q;

    logic                  cmd_legal;
    logic [HADDR_SIZE-1:0] align_mask;
    logic [HDATA_SIZE-1:0] wdata_lane;
    logic [HDATA_SIZE-1:0] rdata_lane;

    logic                  rsp_load;
    logic                  rsp_err_d;
    logic [HDATA_SIZE-1:0] rsp_rdata_d;

    always_comb begin
        align_mask = (HADDR_SIZE'(1) << cmd_size) - HADDR_SIZE'(1);
        cmd_legal  = (cmd_size <= 3'(LANE_W)) && ((cmd_addr & align_mask) == '0);
        wdata_lane = HDATA_SIZE'(lane_replicate(64'(cmd_wdata), cmd_size));
        rdata_lane = HDATA_SIZE'(lane_extract(64'(HRDATA), addr_q[2:0], size_q, HDATA_SIZE));
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        rsp_load    = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_legal) begin
                        state_d = ST_ADDR;
                    end else begin
                        state_d   = ST_RESP;
                        rsp_load  = 1'b1;
                        rsp_err_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (HREADY) state_d = ST_DATA;
            end
            ST_DATA: begin
                // HREADY low covers both wait states and the first ERROR cycle
                if (HREADY) begin
                    state_d     = ST_RESP;
                    rsp_load    = 1'b1;
                    rsp_err_d   = HRESP;
                    rsp_rdata_d = (!HRESP && !write_q) ? rdata_lane : '0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch: only legal commands reach the bus lines
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            wdata_q <= '0;
        end else if (state_q == ST_IDLE && cmd_valid && cmd_legal) begin
            addr_q  <= cmd_addr;
            write_q <= cmd_write;
            size_q  <= cmd_size;
            wdata_q <= wdata_lane;
        end
    end

    // Response register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else if (rsp_load) begin
            rsp_valid <= 1'b1;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
        end else if (state_q == ST_RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end
    end

    // Gating with HRESETn keeps cmd_ready low for the whole reset interval
    assign cmd_ready = (state_q == ST_IDLE) && HRESETn;

    assign HSEL      = (state_q == ST_ADDR);
    assign HTRANS    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = addr_q;
    assign HWRITE    = write_q;
    assign HSIZE     = size_q;
    assign HWDATA    = wdata_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA_PRIV;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_peripheral_uart_ahb3_master.sv
// Directed bench for the UART-side AHB3-Lite master with a hand-driven slave.
module tb_peripheral_uart_ahb3_master;

    logic        HCLK;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int n_assert = 0;
    int n_fail   = 0;

    int          lat;
    int          nonseq_cnt;
    logic [1:0]  a_htrans;
    logic [31:0] a_haddr;
    logic        a_hwrite;
    logic [2:0]  a_hsize;
    logic [31:0] d_hwdata;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;

    peripheral_uart_ahb3_master #(.HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HMASTLOCK(HMASTLOCK), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Present one command, then count edges (handshake edge = 1) until rsp_valid.
    task automatic do_cmd(input logic w, input logic [31:0] a, input logic [2:0] s,
                          input logic [31:0] wd);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_wdata = wd;
        tick();
        cmd_valid  = 1'b0;
        a_htrans   = HTRANS;
        a_haddr    = HADDR;
        a_hwrite   = HWRITE;
        a_hsize    = HSIZE;
        nonseq_cnt = (HTRANS == 2'b10) ? 1 : 0;
        d_hwdata   = '0;
        lat        = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
            if (HTRANS == 2'b10) nonseq_cnt++;
            if (lat == 2) d_hwdata = HWDATA;
        end
    endtask

    // rsp_ready is held high, so the response retires on the next edge.
    task automatic retire(input string tag);
        tick();
        check({tag, "_rsp_clear"}, 64'(rsp_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        HRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_size  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        HRDATA    = '0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_hsel",      64'(HSEL),      64'd0);
        check("rst_htrans",    64'(HTRANS),    64'd0);
        check("rst_haddr",     64'(HADDR),     64'd0);
        check("rst_hwdata",    64'(HWDATA),    64'd0);
        check("rst_hprot",     64'(HPROT),     64'h3);
        check("rst_hburst",    64'(HBURST),    64'd0);
        check("rst_hmastlock", 64'(HMASTLOCK), 64'd0);
        HRESETn = 1'b1;
        #1;
        check("rel_cmd_ready", 64'(cmd_ready), 64'd1);

        // Word write, zero wait
        do_cmd(1'b1, 32'h0000_0004, 3'd2, 32'h0000_0083);
        check("wr_latency",   64'(lat),        64'd3);
        check("wr_a_htrans",  64'(a_htrans),   64'h2);
        check("wr_a_haddr",   64'(a_haddr),    64'h4);
        check("wr_a_hwrite",  64'(a_hwrite),   64'd1);
        check("wr_nonseq",    64'(nonseq_cnt), 64'd1);
        check("wr_hwdata",    64'(d_hwdata),   64'h83);
        check("wr_err",       64'(rsp_err),    64'd0);
        check("wr_rdata",     64'(rsp_rdata),  64'd0);
        retire("wr");

        // Byte and halfword write lane replication
        do_cmd(1'b1, 32'h0000_0002, 3'd0, 32'h0000_00AB);
        check("wrb_hwdata", 64'(d_hwdata), 64'hABAB_ABAB);
        retire("wrb");
        do_cmd(1'b1, 32'h0000_0002, 3'd1, 32'h0000_1234);
        check("wrh_hwdata", 64'(d_hwdata), 64'h1234_1234);
        retire("wrh");

        // Reads with lane extraction
        HRDATA = 32'h11A5_3344;
        do_cmd(1'b0, 32'h0000_0015, 3'd0, 32'h0);
        check("rdb_hsize",  64'(a_hsize),   64'd0);
        check("rdb_hwrite", 64'(a_hwrite),  64'd0);
        check("rdb_rdata",  64'(rsp_rdata), 64'h33);
        check("rdb_err",    64'(rsp_err),   64'd0);
        retire("rdb");
        do_cmd(1'b0, 32'h0000_0002, 3'd1, 32'h0);
        check("rdh_rdata",  64'(rsp_rdata), 64'h11A5);
        retire("rdh");
        do_cmd(1'b0, 32'h0000_0000, 3'd2, 32'h0);
        check("rdw_rdata",  64'(rsp_rdata), 64'h11A5_3344);
        retire("rdw");

        // Word read with three wait states
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0008;
        cmd_size = 3'd2; cmd_wdata = '0;
        tick();
        cmd_valid = 1'b0;
        check("ws_addr_phase", 64'(HTRANS), 64'h2);
        tick();
        hold_addr  = HADDR;
        hold_wdata = HWDATA;
        HREADY = 1'b0;
        HRDATA = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ws_no_rsp",   64'(rsp_valid), 64'd0);
            check("ws_haddr",    64'(HADDR),     64'(hold_addr));
            check("ws_hwdata",   64'(HWDATA),    64'(hold_wdata));
        end
        HREADY = 1'b1;
        HRDATA = 32'hCAFE_0001;
        tick();
        check("ws_rsp_valid", 64'(rsp_valid), 64'd1);
        check("ws_rdata",     64'(rsp_rdata), 64'hCAFE_0001);
        retire("ws");

        // HREADY low during the address phase holds NONSEQ and address
        HREADY = 1'b0;
        do_cmd(1'b1, 32'h0000_0020, 3'd2, 32'h5555_AAAA);
        check("ah_held", 64'(HTRANS), 64'h2);
        HREADY = 1'b1;
        check("ah_haddr", 64'(HADDR), 64'h20);
        tick();
        check("ah_data_phase", 64'(HTRANS), 64'h0);
        tick();
        check("ah_rsp", 64'(rsp_valid), 64'd1);
        retire("ah");
        // The bounded do_cmd loop above timed out by design; restore stimulus

        // Two-cycle slave ERROR
        HRDATA = 32'hFFFF_FFFF;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_000C;
        cmd_size = 3'd2;
        tick();
        cmd_valid = 1'b0;
        tick();
        HREADY = 1'b0;
        HRESP  = 1'b1;
        check("err_c1_htrans", 64'(HTRANS), 64'h0);
        tick();
        check("err_c2_htrans", 64'(HTRANS),    64'h0);
        check("err_c2_norsp",  64'(rsp_valid), 64'd0);
        HREADY = 1'b1;
        tick();
        HRESP = 1'b0;
        check("err_rsp_valid", 64'(rsp_valid), 64'd1);
        check("err_rsp_err",   64'(rsp_err),   64'd1);
        check("err_rsp_rdata", 64'(rsp_rdata), 64'd0);
        retire("err");

        // Rejected commands
        do_cmd(1'b1, 32'h0000_0003, 3'd1, 32'h1);
        check("mis_latency", 64'(lat),        64'd1);
        check("mis_err",     64'(rsp_err),    64'd1);
        check("mis_nonseq",  64'(nonseq_cnt), 64'd0);
        retire("mis");
        do_cmd(1'b0, 32'h0000_0000, 3'd3, 32'h0);
        check("sz3_latency", 64'(lat),        64'd1);
        check("sz3_err",     64'(rsp_err),    64'd1);
        check("sz3_nonseq",  64'(nonseq_cnt), 64'd0);
        check("sz3_rdata",   64'(rsp_rdata),  64'd0);
        retire("sz3");

        // Reset pulse during the data phase
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0010;
        cmd_size = 3'd2; cmd_wdata = 32'h1357_9BDF;
        tick();
        cmd_valid = 1'b0;
        tick();
        HREADY = 1'b0;
        check("rp_pre_hwdata", 64'(HWDATA), 64'h1357_9BDF);
        HRESETn = 1'b0;
        #1;
        check("rp_hsel",      64'(HSEL),      64'd0);
        check("rp_htrans",    64'(HTRANS),    64'd0);
        check("rp_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rp_hwdata",    64'(HWDATA),    64'd0);
        check("rp_haddr",     64'(HADDR),     64'd0);
        tick();
        HREADY  = 1'b1;
        HRESETn = 1'b1;
        #1;

        // Fresh command at the top of the address space
        HRDATA = 32'h5A5A_1234;
        do_cmd(1'b0, 32'hFFFF_FFFC, 3'd2, 32'h0);
        check("top_latency", 64'(lat),       64'd3);
        check("top_haddr",   64'(a_haddr),   64'hFFFF_FFFC);
        check("top_rdata",   64'(rsp_rdata), 64'h5A5A_1234);
        check("top_err",     64'(rsp_err),   64'd0);
        retire("top");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
